// File: rtl/sparrow_pkg.sv
// Shared constants and state encodings for the UART image loader.
package sparrow_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle byte/error strobes.
module uart_rx_byte
    import sparrow_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

    rx_state_t   state;
    logic        sync1, sync2, rx_prev;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shifter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            shifter    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            sync2      <= sync1;
            rx_prev    <= sync2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !sync2) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                // A line that is high again at the start-bit midpoint was only a glitch.
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shifter <= {sync2, shifter[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shifter;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Loads a framed, checksummed image of 32-bit words from a UART stream into IRAM.
module uart_word_loader
    import sparrow_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 868,
    parameter int unsigned AW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          uart_rx_i,
    output logic          we_o,
    output logic [AW-1:0] waddr_o,
    output logic [31:0]   wdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned MAX_WORDS = 32'd1 << AW;

    logic          byte_valid;
    logic [7:0]    rx_byte;
    logic          frame_err;

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [15:0]   words_left;
    logic [1:0]    byte_cnt;
    logic [23:0]   word;
    logic [7:0]    sum;
    logic [15:0]   len_word;
    logic          len_ok;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx_i),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign len_word = {rx_byte, len_lo};
    assign len_ok   = (len_word != 16'd0) && (32'(len_word) <= MAX_WORDS);

    assign busy_o = state inside {S_HDR, S_LEN0, S_LEN1, S_DATA, S_CSUM};
    assign done_o = (state == S_DONE);
    assign err_o  = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
            len_lo     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            sum        <= '0;
        end else begin
            we_o <= 1'b0;
            // Address advances the cycle after each strobe; IDLE->HDR overrides it below.
            if (we_o) begin
                waddr_o <= waddr_o + AW'(1);
            end
            if (!en_i) begin
                state    <= S_IDLE;
                byte_cnt <= '0;
                sum      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state      <= S_HDR;
                        words_left <= '0;
                        byte_cnt   <= '0;
                        waddr_o    <= '0;
                        sum        <= '0;
                    end
                    S_HDR: begin
                        if (frame_err) begin
                            state <= S_ERR;
                        end else if (byte_valid && rx_byte == HDR_BYTE) begin
                            state <= S_LEN0;
                        end
                    end
                    S_LEN0: begin
                        if (frame_err) begin
                            state <= S_ERR;
                        end else if (byte_valid) begin
                            len_lo <= rx_byte;
                            state  <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (frame_err) begin
                            state <= S_ERR;
                        end else if (byte_valid) begin
                            words_left <= len_word;
                            state      <= len_ok ? S_DATA : S_ERR;
                        end
                    end
                    S_DATA: begin
                        if (frame_err) begin
                            state <= S_ERR;
                        end else if (byte_valid) begin
                            sum      <= sum + rx_byte;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                wdata_o    <= {rx_byte, word};
                                we_o       <= 1'b1;
                                words_left <= words_left - 16'd1;
                                if (words_left == 16'd1) begin
                                    state <= S_CSUM;
                                end
                            end else begin
                                word <= {rx_byte, word[23:8]};
                            end
                        end
                    end
                    S_CSUM: begin
                        if (frame_err) begin
                            state <= S_ERR;
                        end else if (byte_valid) begin
                            state <= (rx_byte == sum) ? S_DONE : S_ERR;
                        end
                    end
                    S_DONE, S_ERR: state <= state;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench: a stream-parsing reference model predicts IRAM writes and final status.
module tb_uart_word_loader;

    localparam int unsigned BD = 16;
    localparam int unsigned AW = 4;
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b0;
    logic          uart_rx_i = 1'b1;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [31:0]   wdata_o;
    logic          busy_o, done_o, err_o;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    uart_word_loader #(.BAUD_DIV(BD), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .uart_rx_i (uart_rx_i),
        .we_o      (we_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && we_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", waddr_o, wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("waddr", 64'(waddr_o), 64'(e.addr));
                check("wdata", 64'(wdata_o), 64'(e.data));
            end
        end
    end

    // Reference: find header, read length, gather little-endian words, compare checksum.
    function automatic int model(input bq_t b);
        int i = 0;
        int n, p, s;
        logic [31:0] w;
        while (i < b.size() && b[i] != 8'hA5) i++;
        if (i + 2 >= b.size()) return ST_BUSY;
        n = int'(b[i+1]) + 256 * int'(b[i+2]);
        if (n == 0 || n > (1 << AW)) return ST_ERR;
        p = i + 3;
        s = 0;
        for (int k = 0; k < n; k++) begin
            if (p + 3 >= b.size()) return ST_BUSY;
            w = {b[p+3], b[p+2], b[p+1], b[p]};
            s = s + int'(b[p]) + int'(b[p+1]) + int'(b[p+2]) + int'(b[p+3]);
            exp_q.push_back('{addr: AW'(k % (1 << AW)), data: w});
            p += 4;
        end
        if (p >= b.size()) return ST_BUSY;
        return (int'(b[p]) == (s % 256)) ? ST_DONE : ST_ERR;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk) uart_rx_i = 1'b0;
        repeat (BD) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx_i = b[k];
            repeat (BD) @(negedge clk);
        end
        uart_rx_i = stop_bit;
        repeat (BD) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat ($urandom_range(0, 8)) @(negedge clk);
    endtask

    task automatic send_bytes(input bq_t b);
        foreach (b[k]) send_byte(b[k]);
    endtask

    task automatic start_image(input string name);
        en_i = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_idle_busy"}, 64'(busy_o), 64'(0));
        check({name, "_idle_flags"}, 64'({done_o, err_o}), 64'(0));
        en_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_end(input string name, input int st);
        repeat (6) @(negedge clk);
        check({name, "_done"}, 64'(done_o), 64'(st == ST_DONE));
        check({name, "_err"}, 64'(err_o), 64'(st == ST_ERR));
        check({name, "_busy"}, 64'(busy_o), 64'(st == ST_BUSY));
        check({name, "_writes_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run_image(input string name, input bq_t b);
        int st;
        start_image(name);
        st = model(b);
        send_bytes(b);
        check_end(name, st);
    endtask

    initial begin
        bq_t img, bad_img, part;
        int st;

        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({we_o, busy_o, done_o, err_o}), 64'(0));
        check("rst_waddr", 64'(waddr_o), 64'(0));
        check("rst_wdata", 64'(wdata_o), 64'(0));
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_after_rst", 64'({we_o, busy_o, done_o, err_o}), 64'(0));

        img = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        run_image("good2", img);
        bad_img = img;
        bad_img[11] = 8'h65;
        run_image("badsum", bad_img);
        run_image("lead_junk", '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00,
                                 8'h01, 8'h00, 8'h00, 8'h00, 8'h01});
        run_image("len_zero", '{8'hA5, 8'h00, 8'h00});
        run_image("len_17", '{8'hA5, 8'h11, 8'h00});
        run_image("len_16", '{8'hA5, 8'h10, 8'h00});

        start_image("frame");
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22});
        send_byte(8'h33, 1'b0);
        check_end("frame", ST_ERR);

        // Short low glitch during LEN0 must not be taken as a byte.
        start_image("glitch");
        img = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        st = model(img);
        send_byte(8'hA5);
        @(negedge clk) uart_rx_i = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (3 * BD) @(negedge clk);
        img.delete(0);
        send_bytes(img);
        check_end("glitch", st);

        start_image("rst_mid");
        part = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        void'(model(part));
        send_bytes(part);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({we_o, busy_o, done_o, err_o}), 64'(0));
        check("rst_mid_waddr", 64'(waddr_o), 64'(0));
        check("rst_mid_wdata", 64'(wdata_o), 64'(0));
        check("rst_mid_pending", 64'(exp_q.size()), 64'(0));
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        img = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        st = model(img);
        send_bytes(img);
        check_end("rst_retx", st);

        for (int t = 0; t < 10; t++) begin
            bq_t r;
            int n, sel, sm;
            logic [7:0] v;
            logic [15:0] n16;
            repeat ($urandom_range(0, 2)) begin
                do v = 8'($urandom); while (v == 8'hA5);
                r.push_back(v);
            end
            r.push_back(8'hA5);
            sel = $urandom_range(0, 9);
            if (sel == 0) n = 0;
            else if (sel == 1) n = $urandom_range(17, 300);
            else n = $urandom_range(1, 6);
            n16 = 16'(n);
            r.push_back(n16[7:0]);
            r.push_back(n16[15:8]);
            if (n >= 1 && n <= 16) begin
                sm = 0;
                for (int k = 0; k < 4 * n; k++) begin
                    v = 8'($urandom);
                    sm += int'(v);
                    r.push_back(v);
                end
                v = 8'(sm);
                if ($urandom_range(0, 3) == 0) v = v ^ 8'($urandom_range(1, 255));
                r.push_back(v);
            end
            run_image($sformatf("rand%0d", t), r);
        end

        en_i = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_word_loader.md
UART_WORD_LOADER -- requirements
Module: uart_word_loader

Interface
REQ-001 Parameter: BAUD_DIV, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Parameter: AW, default 12, IRAM word-address width.
REQ-003 clk  input  1  system clock; the block's only clock.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en_i  input  1  loader enable; low forces IDLE.
REQ-006 uart_rx_i  input  1  serial input, idle high, 8N1, LSB first; asynchronous to clk.
REQ-007 we_o  output  1  one-cycle IRAM write strobe.
REQ-008 waddr_o  output  AW  IRAM word address.
REQ-009 wdata_o  output  32  IRAM write word.
REQ-010 busy_o  output  1  high in the HDR, LEN0, LEN1, DATA and CSUM states.
REQ-011 done_o  output  1  image loaded with a good checksum.
REQ-012 err_o  output  1  framing, length or checksum error.

Function
REQ-013 Synchronise uart_rx_i with two flops before any other use.
REQ-014 Detect a start bit on a synchronised 1->0 edge; resample at BAUD_DIV/2; if the line is high, discard as a false start.
REQ-015 Sample the 8 data bits and the stop bit at successive BAUD_DIV intervals from the start-bit midpoint.
REQ-016 At the stop-bit sample, emit a 1-cycle byte_valid with the byte; a stop bit of 0 emits a 1-cycle frame_err instead.
REQ-017 Loader FSM states: IDLE, HDR, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-018 IDLE -> HDR when en_i=1.
REQ-019 HDR: byte 0xA5 -> LEN0; any other byte is ignored and the FSM stays in HDR.
REQ-020 LEN0 and LEN1 capture the word count N, little-endian, as 16 bits.
REQ-021 LEN1: N=0 or N>2^AW -> ERR with no writes; otherwise -> DATA.
REQ-022 DATA assembles words little-endian: the first byte is wdata_o[7:0].
REQ-023 we_o asserts for exactly 1 cycle, on the cycle after the 4th byte's byte_valid.
REQ-024 The first write uses waddr_o=0; waddr_o increments by 1 after each write and wraps modulo 2^AW.
REQ-025 After the Nth write the FSM -> CSUM.
REQ-026 A running 8-bit sum (mod 256) covers all 4N data bytes only; the header and length bytes are excluded.
REQ-027 CSUM: received byte == sum -> DONE; otherwise -> ERR.
REQ-028 frame_err in any state other than IDLE, DONE or ERR -> ERR.
REQ-029 DONE and ERR hold until en_i=0, then -> IDLE.
REQ-030 done_o = (state==DONE); err_o = (state==ERR).
REQ-031 en_i=0 in any state -> IDLE next cycle, with no further we_o.
REQ-032 Partially assembled bytes and the sum are discarded on that transition.
REQ-033 Re-entering HDR clears the word count, byte counter, address and sum.
REQ-034 A byte_valid coincident with the en_i 1->0 transition is dropped.
REQ-035 In DONE and ERR, received bytes are ignored.

Reset
REQ-036 rst=1 asynchronously sets: state=IDLE, and we_o, waddr_o, wdata_o, busy_o, done_o, err_o all 0.
REQ-037 rst=1 also sets the synchroniser flops to 1 and clears the bit counter, baud counter and sum.
REQ-038 Reset mid-frame or mid-image aborts with no further writes.
REQ-039 After reset release, no spurious start is detected while the line is idle high.

Structure
REQ-040 The header constant 0xA5 and the FSM state enum reside in shared package sparrow_pkg.
REQ-041 Sub-module uart_rx_byte (synchroniser, baud counter, bit shifter; outputs byte_valid, byte, frame_err) is instantiated once.
REQ-042 The loader FSM, word assembler, address counter and checksum reside in uart_word_loader.

Verification (BAUD_DIV=16, AW=4)
REQ-043 en_i=1; send A5 02 00 11 22 33 44 55 66 77 88 0x64 -> two writes:
  - 0x44332211 @ addr 0, then 0x88776655 @ addr 1;
  - then done_o=1, busy_o=0.
REQ-044 Same image with checksum byte 0x65 -> both writes occur, then err_o=1, done_o=0.
REQ-045 Send 00 FF A5 01 00 01 00 00 00 01 -> leading bytes ignored; single write 0x00000001 @ addr 0; done_o=1.
REQ-046 Send A5 00 00 -> err_o=1 with zero writes; send A5 11 00 (N=17 > 16) -> err_o=1 with zero writes.
REQ-047 Drive a stop bit of 0 on the 3rd data byte -> err_o=1, no write; a 4-cycle low glitch on idle line -> no byte.
REQ-048 Assert rst for 1 cycle after 6 of 8 data bytes -> all outputs 0 immediately; retransmit the full image -> writes restart at addr 0.
